// File: rtl/sa_core_if.sv
// Operand feed and result drain bundle for sa_core.
// The feeder side drives operands and outread; the core drives results back.
interface sa_core_if #(
    parameter int ROWS = 8
);
    logic signed [7:0]  ainport    [ROWS];
    logic signed [7:0]  winport    [ROWS];
    logic               inpvalid;
    logic               outread;
    logic signed [31:0] routport   [ROWS];
    logic [0:ROWS-1]    rvalidport;

    modport master (
        output ainport, winport, inpvalid, outread,
        input  routport, rvalidport
    );

    modport slave (
        input  ainport, winport, inpvalid, outread,
        output routport, rvalidport
    );
endinterface

// File: rtl/sa_core.sv
// Output-stationary ROWSxROWS systolic matrix-multiply core: C = A*W over K-beat blocks,
// signed 8-bit operands, 32-bit wrapping accumulators, one drain port per result row.
module sa_core #(
    parameter int ROWS = 8,
    parameter int K    = 8
) (
    input logic      clk,
    input logic      rstn,
    sa_core_if.slave bus
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_w;

    // Lane skew shift registers; lane r is tapped at stage r.
    logic [7:0]  ask_q [ROWS][ROWS];
    logic        avs_q [ROWS][ROWS];
    logic        als_q [ROWS][ROWS];
    logic [7:0]  wsk_q [ROWS][ROWS];

    // Per-PE forwarding registers (activation + tags right, weight down).
    logic [7:0]  af_q  [ROWS][ROWS];
    logic        vf_q  [ROWS][ROWS];
    logic        lf_q  [ROWS][ROWS];
    logic [7:0]  wf_q  [ROWS][ROWS];

    logic [7:0]  a_in  [ROWS][ROWS];
    logic [7:0]  w_in  [ROWS][ROWS];
    logic        v_in  [ROWS][ROWS];
    logic        l_in  [ROWS][ROWS];
    logic [15:0] p16   [ROWS][ROWS];
    logic [31:0] prod  [ROWS][ROWS];

    logic [31:0] acc_q [ROWS][ROWS];
    logic [31:0] sh_q  [ROWS][ROWS];
    logic        cap_q [ROWS];

    logic [31:0]   ob_q  [ROWS][ROWS];
    logic [PW-1:0] ptr_q [ROWS];
    logic [PW-1:0] ptr_d [ROWS];
    logic [0:ROWS-1] rv_q, rv_d;

    always_comb begin
        last_w = bus.inpvalid && (cnt_q == CW'(K - 1));
        cnt_d  = cnt_q;
        if (bus.inpvalid) begin
            cnt_d = last_w ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // PE operand selection and 8x8 signed multiply (sign-extended to 16 bits first).
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < ROWS; c++) begin
                if (c == 0) begin
                    a_in[r][c] = ask_q[r][r];
                    v_in[r][c] = avs_q[r][r];
                    l_in[r][c] = als_q[r][r];
                end else begin
                    a_in[r][c] = af_q[r][c-1];
                    v_in[r][c] = vf_q[r][c-1];
                    l_in[r][c] = lf_q[r][c-1];
                end
                if (r == 0) begin
                    w_in[r][c] = wsk_q[c][c];
                end else begin
                    w_in[r][c] = wf_q[r-1][c];
                end
                p16[r][c]  = {{8{a_in[r][c][7]}}, a_in[r][c]} * {{8{w_in[r][c][7]}}, w_in[r][c]};
                prod[r][c] = {{16{p16[r][c][15]}}, p16[r][c]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < ROWS; c++) begin
                    ask_q[r][c] <= '0;
                    avs_q[r][c] <= 1'b0;
                    als_q[r][c] <= 1'b0;
                    wsk_q[r][c] <= '0;
                    af_q[r][c]  <= '0;
                    vf_q[r][c]  <= 1'b0;
                    lf_q[r][c]  <= 1'b0;
                    wf_q[r][c]  <= '0;
                    acc_q[r][c] <= '0;
                    sh_q[r][c]  <= '0;
                end
                cap_q[r] <= 1'b0;
            end
        end else begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                ask_q[r][0] <= bus.ainport[r];
                avs_q[r][0] <= bus.inpvalid;
                als_q[r][0] <= last_w;
                wsk_q[r][0] <= bus.winport[r];
                for (int unsigned i = 1; i < ROWS; i++) begin
                    ask_q[r][i] <= ask_q[r][i-1];
                    avs_q[r][i] <= avs_q[r][i-1];
                    als_q[r][i] <= als_q[r][i-1];
                    wsk_q[r][i] <= wsk_q[r][i-1];
                end
            end
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < ROWS; c++) begin
                    af_q[r][c] <= a_in[r][c];
                    vf_q[r][c] <= v_in[r][c];
                    lf_q[r][c] <= l_in[r][c];
                    wf_q[r][c] <= w_in[r][c];
                    if (v_in[r][c]) begin
                        if (l_in[r][c]) begin
                            sh_q[r][c]  <= acc_q[r][c] + prod[r][c];
                            acc_q[r][c] <= '0;
                        end else begin
                            acc_q[r][c] <= acc_q[r][c] + prod[r][c];
                        end
                    end
                end
                // The rightmost PE finishing its last beat means the whole shadow row is final.
                cap_q[r] <= v_in[r][ROWS-1] && l_in[r][ROWS-1];
            end
        end
    end

    // Row copy takes priority over a concurrent read on the same row.
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            ptr_d[r] = ptr_q[r];
            rv_d[r]  = rv_q[r];
            if (cap_q[r]) begin
                ptr_d[r] = '0;
                rv_d[r]  = 1'b1;
            end else if (bus.outread && rv_q[r]) begin
                if (ptr_q[r] == PW'(ROWS - 1)) begin
                    ptr_d[r] = '0;
                    rv_d[r]  = 1'b0;
                end else begin
                    ptr_d[r] = ptr_q[r] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rv_q <= '0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                ptr_q[r] <= '0;
                for (int unsigned c = 0; c < ROWS; c++) begin
                    ob_q[r][c] <= '0;
                end
            end
        end else begin
            rv_q <= rv_d;
            for (int unsigned r = 0; r < ROWS; r++) begin
                ptr_q[r] <= ptr_d[r];
                if (cap_q[r]) begin
                    for (int unsigned c = 0; c < ROWS; c++) begin
                        ob_q[r][c] <= sh_q[r][c];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.rvalidport = rv_q;
        for (int unsigned r = 0; r < ROWS; r++) begin
            bus.routport[r] = rv_q[r] ? ob_q[r][ptr_q[r]] : '0;
        end
    end
endmodule

// File: tb/tb_sa_core.sv
// Bench for sa_core: directed and randomized blocks checked every cycle against a
// matrix-level model of the results and per-row drain state.
module tb_sa_core;
    localparam int ROWS = 8;
    localparam int K    = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int vectors     = 0;
    int miscompares = 0;

    sa_core_if #(.ROWS(ROWS)) bus ();
    sa_core #(.ROWS(ROWS), .K(K)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                   due;
        int                   row;
        logic [ROWS*32-1:0]   v;
    } cap_t;

    cap_t               pend[$];
    logic [31:0]        macc [ROWS][ROWS];
    int                 mcnt;
    int                 now;
    logic [31:0]        mob  [ROWS][ROWS];
    int                 mptr [ROWS];
    bit                 mval [ROWS];
    bit                 cp   [ROWS];
    logic [ROWS*32-1:0] cv   [ROWS];

    task automatic model_clear();
        pend.delete();
        mcnt = 0;
        for (int r = 0; r < ROWS; r++) begin
            mptr[r] = 0;
            mval[r] = 1'b0;
            for (int c = 0; c < ROWS; c++) begin
                macc[r][c] = '0;
                mob[r][c]  = '0;
            end
        end
    endtask

    task automatic model_edge();
        logic [ROWS*32-1:0] v;
        now++;
        for (int r = 0; r < ROWS; r++) cp[r] = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == now) begin
                cp[pend[i].row] = 1'b1;
                cv[pend[i].row] = pend[i].v;
                pend.delete(i);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (cp[r]) begin
                for (int c = 0; c < ROWS; c++) mob[r][c] = cv[r][c*32 +: 32];
                mptr[r] = 0;
                mval[r] = 1'b1;
            end else if (bus.outread && mval[r]) begin
                if (mptr[r] == ROWS - 1) begin
                    mptr[r] = 0;
                    mval[r] = 1'b0;
                end else begin
                    mptr[r]++;
                end
            end
        end
        if (bus.inpvalid) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < ROWS; c++)
                    macc[r][c] = macc[r][c] + 32'(int'(bus.ainport[r]) * int'(bus.winport[c]));
            if (mcnt == K - 1) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < ROWS; c++) begin
                        v[c*32 +: 32] = macc[r][c];
                        macc[r][c]    = '0;
                    end
                    pend.push_back('{due: now + ROWS + 1 + r, row: r, v: v});
                end
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_clear();
        else       model_edge();
    end

    always @(negedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            chk("rvalid_row", 32'(bus.rvalidport[r]), 32'(mval[r]));
            chk("rout_row", bus.routport[r], mval[r] ? mob[r][mptr[r]] : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic garbage();
        for (int i = 0; i < ROWS; i++) begin
            bus.ainport[i] = 8'($urandom);
            bus.winport[i] = 8'($urandom);
        end
    endtask

    task automatic step(input bit v, input bit rd);
        bus.inpvalid = v;
        bus.outread  = rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rd);
        repeat (n) begin
            garbage();
            step(1'b0, rd);
        end
    endtask

    task automatic load(input int mode, input int k);
        for (int i = 0; i < ROWS; i++) begin
            case (mode)
                0: begin bus.ainport[i] = 8'(8 * i + k); bus.winport[i] = (k == i) ? 8'sd1 : 8'sd0; end
                1: begin bus.ainport[i] = 8'(k);         bus.winport[i] = 8'sd1; end
                2: begin bus.ainport[i] = 8'h80;         bus.winport[i] = 8'h80; end
                3: begin bus.ainport[i] = 8'hFF;         bus.winport[i] = 8'h01; end
                4: begin bus.ainport[i] = 8'sd2;         bus.winport[i] = 8'sd3; end
                default: begin bus.ainport[i] = 8'($urandom); bus.winport[i] = 8'($urandom); end
            endcase
        end
    endtask

    task automatic send_block(input int mode, input bit gap);
        for (int k = 0; k < K; k++) begin
            if (gap && k > 0) begin
                garbage();
                step(1'b0, 1'b0);
            end
            load(mode, k);
            step(1'b1, 1'b0);
        end
    endtask

    // Drain all rows with outread held, checking every column against one constant.
    task automatic drain_const(input string name, input logic [31:0] v);
        for (int i = 0; i < ROWS; i++) begin
            for (int r = 0; r < ROWS; r++) chk(name, bus.routport[r], v);
            step(1'b0, 1'b1);
        end
        chk({name, "_cleared"}, 32'(bus.rvalidport), 32'd0);
    endtask

    initial begin
        logic [0:ROWS-1] m;
        bus.inpvalid = 1'b0;
        bus.outread  = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            bus.ainport[i] = '0;
            bus.winport[i] = '0;
        end
        #1 rstn = 1'b0;
        @(negedge clk);

        // Reset held while inputs toggle.
        repeat (6) begin
            garbage();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("reset_rvalid", 32'(bus.rvalidport), 32'd0);
        for (int r = 0; r < ROWS; r++) chk("reset_rout", bus.routport[r], 32'd0);
        rstn = 1'b1;

        // Partial block, then reset mid-block.
        for (int k = 0; k < 4; k++) begin
            load(1, k);
            step(1'b1, 1'b0);
        end
        #2 rstn = 1'b0;
        idle(2, 1'b0);
        rstn = 1'b1;
        chk("midreset_rvalid", 32'(bus.rvalidport), 32'd0);

        // Identity weights with latency checks.
        send_block(0, 1'b0);
        idle(8, 1'b0);
        chk("ident_row0_early", 32'(bus.rvalidport[0]), 32'd0);
        idle(1, 1'b0);
        chk("ident_row0_T9", 32'(bus.rvalidport[0]), 32'd1);
        chk("ident_row1_T9", 32'(bus.rvalidport[1]), 32'd0);
        idle(6, 1'b0);
        chk("ident_row7_T15", 32'(bus.rvalidport[7]), 32'd0);
        idle(1, 1'b0);
        chk("ident_row7_T16", 32'(bus.rvalidport[7]), 32'd1);
        for (int i = 0; i < ROWS; i++) begin
            for (int r = 0; r < ROWS; r++) chk("ident_val", bus.routport[r], 32'(8 * r + i));
            step(1'b0, 1'b1);
        end
        chk("ident_cleared", 32'(bus.rvalidport), 32'd0);

        // Ones weights.
        send_block(1, 1'b0);
        idle(16, 1'b0);
        drain_const("ones_val", 32'd28);

        // Signed extremes.
        send_block(2, 1'b0);
        idle(16, 1'b0);
        drain_const("neg128_val", 32'd131072);
        send_block(3, 1'b0);
        idle(16, 1'b0);
        drain_const("neg1_val", 32'hFFFF_FFF8);

        // Gapped input: latency measured from the last beat only.
        send_block(1, 1'b1);
        for (int j = 1; j <= 17; j++) begin
            idle(1, 1'b0);
            for (int r = 0; r < ROWS; r++) m[r] = (j >= ROWS + 1 + r);
            chk("gap_rvalid_mask", 32'(bus.rvalidport), 32'(m));
        end
        drain_const("gap_val", 32'd28);

        // Back-to-back blocks with no idle cycle.
        send_block(1, 1'b0);
        send_block(4, 1'b0);
        idle(8, 1'b0);
        chk("b2b_first_rvalid", 32'(bus.rvalidport), 32'hFF);
        for (int r = 0; r < ROWS; r++) chk("b2b_first_val", bus.routport[r], 32'd28);
        idle(9, 1'b0);
        drain_const("b2b_second_val", 32'd48);

        // Randomized blocks, gaps and reads.
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < K; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    garbage();
                    step(1'b0, 1'($urandom_range(0, 1)));
                end
                load(5, k);
                step(1'b1, 1'($urandom_range(0, 1)));
            end
        end
        idle(30, 1'b1);
        chk("final_empty", 32'(bus.rvalidport), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget, got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
